// File: rtl/seg7_bcd_conv.sv
// Binary-to-packed-BCD converter for the 8-digit 7-segment scanner.
// Sequential double-dabble engine, with hex pass-through and an overflow pattern.
module seg7_bcd_conv #(
    parameter int                IN_W    = 32,
    parameter int                DIGITS  = 8,
    parameter logic [IN_W-1:0]   DEC_MAX = 32'd99999999,
    parameter logic [4*DIGITS-1:0] OVF_PAT = 32'hEEEEEEEE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FINISH
    } state_t;

    localparam logic [5:0] LAST_ITER = 6'(IN_W - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [IN_W-1:0]       r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [5:0]            r_cnt;
    logic [4*DIGITS-1:0]   r_data;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_too_big;
    logic                  w_last;
    logic [4*DIGITS-1:0]   w_bcd_adj;
    logic [4*DIGITS-1:0]   w_bcd_shift;
    logic [IN_W-1:0]       w_bin_shift;

    assign w_too_big = (bin_in > DEC_MAX);
    assign w_last    = (r_cnt == LAST_ITER);

    // Add-3 correction on every nibble in parallel, then shift {bcd, bin} left by one.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                            : r_bcd[4*i +: 4];
        end
    end

    assign w_bcd_shift = {w_bcd_adj[4*DIGITS-2:0], r_bin[IN_W-1]};
    assign w_bin_shift = {r_bin[IN_W-2:0], 1'b0};

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (mode || w_too_big) ? S_FINISH : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the shift registers are plain flops, so they are reset along with the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_bin <= bin_in;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= !mode && w_too_big;
            if (mode) begin
                r_data <= bin_in;
            end else if (w_too_big) begin
                r_data <= OVF_PAT;
            end
        end else if (r_state == S_SHIFT) begin
            r_bin <= w_bin_shift;
            r_bcd <= w_bcd_shift;
            r_cnt <= r_cnt + 6'd1;
            // The last shift lands directly in data_out so FINISH shows the result.
            if (w_last) begin
                r_data <= w_bcd_shift;
            end
        end
    end

    assign busy     = (r_state == S_SHIFT);
    assign done     = (r_state == S_FINISH);
    assign ovf      = r_ovf;
    assign data_out = r_data;

endmodule

// File: tb/tb_seg7_bcd_conv.sv
// Self-checking bench for seg7_bcd_conv: directed vector table, multi-cycle
// corner sequences, and randomized conversions against an arithmetic model.
module tb_seg7_bcd_conv;

    localparam logic [31:0] DEC_MAX = 32'd99999999;
    localparam logic [31:0] OVF_PAT = 32'hEEEEEEEE;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [31:0] data_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_prev = 32'd0;

    seg7_bcd_conv dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] bin;
        logic [31:0] exp_data;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by repeated division, not by shifting.
    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r = '0;
        longint unsigned x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model(input logic m, input logic [31:0] b,
                         output logic [31:0] d, output logic o, output int lat);
        if (m) begin
            d = b; o = 1'b0; lat = 1;
        end else if (b > DEC_MAX) begin
            d = OVF_PAT; o = 1'b1; lat = 1;
        end else begin
            d = to_bcd(b); o = 1'b0; lat = 33;
        end
    endtask

    // One request from IDLE; watches busy/hold each cycle, then checks the result.
    task automatic do_conv(input string name, input logic m, input logic [31:0] b,
                           input logic [31:0] exp_data, input logic exp_ovf, input int exp_lat);
        int   cyc = 1;
        logic busy_bad = 1'b0;
        logic hold_bad = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = m; bin_in = b;
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 40) begin
            if (busy !== (exp_lat == 33)) busy_bad = 1'b1;
            if (data_out !== exp_prev) hold_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, cyc, exp_lat);
        check({name, " busy"}, {31'd0, busy_bad}, 32'd0);
        check({name, " hold"}, {31'd0, hold_bad}, 32'd0);
        check({name, " data"}, data_out, exp_data);
        check({name, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        check({name, " busy@done"}, {31'd0, busy}, 32'd0);
        exp_prev = exp_data;
        @(negedge clk);
        check({name, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] md;
        logic        mo;
        int          ml;
        logic        flag;
        int          cyc;

        vecs.push_back('{"dec 12345678", 1'b0, 32'd12345678,  32'h12345678, 1'b0, 33});
        vecs.push_back('{"dec max",      1'b0, 32'd99999999,  32'h99999999, 1'b0, 33});
        vecs.push_back('{"dec zero",     1'b0, 32'd0,         32'h00000000, 1'b0, 33});
        vecs.push_back('{"dec max+1",    1'b0, 32'd100000000, 32'hEEEEEEEE, 1'b1, 1});
        vecs.push_back('{"hex clr ovf",  1'b1, 32'hDEADBEEF,  32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{"dec all ones", 1'b0, 32'hFFFFFFFF,  32'hEEEEEEEE, 1'b1, 1});
        vecs.push_back('{"dec 10",       1'b0, 32'd10,        32'h00000010, 1'b0, 33});
        vecs.push_back('{"hex zero",     1'b1, 32'd0,         32'h00000000, 1'b0, 1});
        vecs.push_back('{"dec 90909",    1'b0, 32'd90909,     32'h00090909, 1'b0, 33});

        rst = 1'b1; start = 1'b0; mode = 1'b0; bin_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset data", data_out, 32'd0);
        check("reset flags", {29'd0, busy, done, ovf}, 32'd0);

        foreach (vecs[i]) begin
            do_conv(vecs[i].name, vecs[i].mode, vecs[i].bin,
                    vecs[i].exp_data, vecs[i].exp_ovf, vecs[i].exp_lat);
        end

        // Start during SHIFT must be ignored.
        flag = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; bin_in = 32'd255;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start = (k == 10); mode = 1'b1; bin_in = 32'd1;
            if (k < 33 && (done || !busy)) flag = 1'b1;
        end
        check("ignore start seq", {31'd0, flag}, 32'd0);
        check("ignore start done", {31'd0, done}, 32'd1);
        check("ignore start data", data_out, 32'h00000255);
        exp_prev = 32'h00000255;
        start = 1'b0;
        @(negedge clk);

        // Reset mid-SHIFT aborts with no done pulse.
        flag = 1'b0;
        start = 1'b1; mode = 1'b0; bin_in = 32'd4095;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (k == 15);
        end
        check("abort data", data_out, 32'd0);
        check("abort flags", {29'd0, busy, done, ovf}, 32'd0);
        repeat (25) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        check("abort no done", {31'd0, flag}, 32'd0);
        exp_prev = 32'd0;
        do_conv("after abort", 1'b0, 32'd4095, 32'h00004095, 1'b0, 33);

        // start held high: back-to-back decimal conversions every 34 cycles.
        start = 1'b1; mode = 1'b0; bin_in = 32'd42;
        cyc = 0;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        check("b2b first done", {31'd0, done}, 32'd1);
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 40) begin @(negedge clk); cyc++; end
        start = 1'b0;
        check("b2b period", cyc, 34);
        check("b2b data", data_out, 32'h00000042);
        exp_prev = 32'h00000042;
        @(negedge clk);

        // Randomized requests against the arithmetic model.
        for (int i = 0; i < 24; i++) begin
            logic        rm;
            logic [31:0] rb;
            rm = 1'($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = DEC_MAX + 32'($urandom_range(0, 3)) - 32'd1;
                default: rb = 32'($urandom_range(0, 99999999));
            endcase
            model(rm, rb, md, mo, ml);
            do_conv($sformatf("rand%0d", i), rm, rb, md, mo, ml);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_bcd_conv.md
Name: seg7_bcd_conv

Overview:
Upstream feeder for the 8-digit 7-segment scanner. It takes a 32-bit binary value from the CPU's MMIO display register and converts it to 8 packed BCD nibbles with a sequential double-dabble engine, or passes it through unchanged in hex mode. The result drives the scanner's 32-bit data input and is held stable between conversions, so the display never shows intermediate values.

Parameters:
IN_W, 32, width of the binary input (fixed at 32; other values are not supported).
DIGITS, 8, number of BCD output digits; output width is 4*DIGITS.
DEC_MAX, 99999999, largest decimal value that fits in DIGITS digits.
OVF_PAT, 32'hEEEEEEEE, pattern driven on data_out when the decimal value overflows.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  request a conversion; sampled only in IDLE
mode  in  1  0 = decimal (BCD), 1 = hex pass-through; sampled with start
bin_in  in  32  binary value; sampled with start
busy  out  1  high while a decimal conversion is in SHIFT
done  out  1  one-cycle pulse in the cycle data_out first shows the new result
ovf  out  1  decimal value exceeded DEC_MAX; held until the next accepted start
data_out  out  32  packed digits, nibble i = digit i (LSD in [3:0]); feeds the scanner data input

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: data_out=0, busy=0, done=0, ovf=0, state=IDLE, iteration counter=0, internal shift registers=0.
- States:
  - IDLE: start=1 accepts a request in cycle t; bin_in and mode are latched; ovf clears.
  - SHIFT: active only for an in-range decimal request.
  - FINISH: a single cycle that updates data_out and pulses done; returns to IDLE next cycle.
- Hex mode (mode=1): IDLE -> FINISH. In cycle t+1, data_out=bin_in and done=1. busy stays 0. Latency is 1 cycle.
- Decimal mode, overflow (bin_in > DEC_MAX, unsigned compare): IDLE -> FINISH. In cycle t+1, data_out=OVF_PAT, ovf=1, done=1. busy stays 0.
- Decimal mode, in range: IDLE -> SHIFT with a 32-bit binary shift register holding bin_in, a 32-bit BCD accumulator cleared to 0, and a 6-bit iteration counter set to 0.
- Each SHIFT cycle:
  - Every BCD nibble that is >= 5 gets +3 (combinational, all nibbles in parallel).
  - The {BCD, binary} pair then shifts left 1, so the binary MSB enters BCD bit 0.
  - The counter increments.
- SHIFT runs for exactly 32 cycles (t+1..t+32) with busy=1. After the 32nd shift, go to FINISH.
- FINISH at t+33: data_out=BCD accumulator, done=1, busy=0. Total latency is 33 cycles from accept to done.
- data_out holds its previous value throughout SHIFT and changes only in FINISH or on reset.
- start while in SHIFT or FINISH is ignored; it is not queued.
- start held high continuously: a new request is accepted in every IDLE cycle. The cycle after FINISH is IDLE, so back-to-back decimal conversions repeat every 34 cycles.
- rst asserted mid-SHIFT aborts the conversion. All outputs return to reset values on the next edge, and no done pulse is produced.
- done and busy are never high in the same cycle.
- Boundaries:
  - bin_in=0 produces 0x00000000.
  - bin_in=DEC_MAX is in range.
  - bin_in=DEC_MAX+1 is overflow.
  - The counter compares against 31 to exit and never wraps.

Test Plan:
- Reset, then decimal start with bin_in=12345678 -> busy high for 32 cycles; done at t+33 with data_out=0x12345678, ovf=0; data_out equals the prior value up to t+32.
- Decimal bin_in=99999999, then bin_in=0 -> data_out=0x99999999, then 0x00000000, each after 33 cycles.
- Decimal bin_in=100000000 -> at t+1: done=1, ovf=1, data_out=0xEEEEEEEE, busy never high. A following hex start clears ovf.
- Hex start with bin_in=0xDEADBEEF -> at t+1: data_out=0xDEADBEEF, done=1, busy=0.
- Decimal start with 255, a second start (hex, 0x1) pulsed at t+10 -> second start ignored; done only at t+33 with data_out=0x00000255.
- Decimal start with 4095, rst=1 at t+15 for one cycle -> data_out=0, busy=0, no done. A fresh start with 4095 then yields 0x00004095 after 33 cycles.
